// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store unit bus controller. It accepts one load or store
// request, runs it as one (or, when split, two) word-aligned bus beats and
// returns a one-cycle response with the extended load data or a fault.
// Optional macro LSU_MISALIGN_SPLIT_EN: when defined, misaligned accesses are
// split into two bus beats (BEAT0 then BEAT1). When undefined, they fault
// without any bus activity.
module lsu_bus_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        mem_op,
  input  logic [2:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_re,
  output logic [3:0]        bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_err
);

  localparam int unsigned CNT_W = 8;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam int unsigned LANE_W   = 64;
  localparam bit          SPLIT_EN = 1'b1;
`else
  localparam int unsigned LANE_W   = 32;
  localparam bit          SPLIT_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [1:0]        op_q;
  logic [2:0]        sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              capture;

  logic              req_ready_d, busy_d;
  logic              rsp_valid_d, rsp_fault_d;
  logic [31:0]       rsp_rdata_d;
  logic              bus_req_d, bus_re_d;
  logic [3:0]        bus_we_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [31:0]       bus_wdata_d;

  logic [1:0]        src_op;
  logic [2:0]        src_sel;
  logic [ADDR_W-1:0] src_addr;
  logic [31:0]       src_wdata;
  logic [3:0]        base_mask;
  logic [31:0]       data_mask;
  logic [7:0]        lane_mask;
  logic [LANE_W-1:0] lane_data;
  logic              misaligned;
  logic [ADDR_W-1:0] word_addr;
  logic              src_load, src_store;

  logic [31:0]       aligned_rd;
  logic [31:0]       load_data;
  logic              beat_end, beat_fault, go_beat1;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]       rdata0_q;
  logic [63:0]       merged_rd;
`endif

  // Request source: live inputs while idle, captured request otherwise
  always_comb begin
    src_op    = op_q;
    src_sel   = sel_q;
    src_addr  = addr_q;
    src_wdata = wdata_q;
    if (state == ST_IDLE) begin
      src_op    = mem_op;
      src_sel   = mem_sel;
      src_addr  = mem_addr;
      src_wdata = mem_wdata;
    end
  end

  // Byte-lane placement of the access relative to the word boundary
  always_comb begin
    case (src_sel)
      3'b000, 3'b100: base_mask = 4'b0001;
      3'b001, 3'b101: base_mask = 4'b0011;
      default:        base_mask = 4'b1111;
    endcase
    data_mask  = {{8{base_mask[3]}}, {8{base_mask[2]}},
                  {8{base_mask[1]}}, {8{base_mask[0]}}};
    lane_mask  = {4'b0000, base_mask} << src_addr[1:0];
    lane_data  = LANE_W'(src_wdata & data_mask) << {src_addr[1:0], 3'b000};
    misaligned = |lane_mask[7:4];
    word_addr  = {src_addr[ADDR_W-1:2], 2'b00};
    src_load   = (src_op == OP_LOAD);
    src_store  = (src_op == OP_STORE);
  end

  // Load data alignment (merging both beats when split) and extension
  always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
    merged_rd  = (state == ST_BEAT1) ? {bus_rdata, rdata0_q} : {32'd0, bus_rdata};
    aligned_rd = 32'(merged_rd >> {addr_q[1:0], 3'b000});
`else
    aligned_rd = bus_rdata >> {addr_q[1:0], 3'b000};
`endif
    case (sel_q)
      3'b000:  load_data = {{24{aligned_rd[7]}}, aligned_rd[7:0]};
      3'b100:  load_data = {24'd0, aligned_rd[7:0]};
      3'b001:  load_data = {{16{aligned_rd[15]}}, aligned_rd[15:0]};
      3'b101:  load_data = {16'd0, aligned_rd[15:0]};
      default: load_data = aligned_rd;
    endcase
  end

  // Beat completion: error wins over ack, timeout when the counter runs out
  always_comb begin
    beat_end   = bus_err || bus_ack || (cnt == CNT_LAST);
    beat_fault = bus_err || !bus_ack;
`ifdef LSU_MISALIGN_SPLIT_EN
    go_beat1   = misaligned && bus_ack && !bus_err;
`else
    go_beat1   = 1'b0;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    capture     = 1'b0;
    bus_req_d   = bus_req;
    bus_re_d    = bus_re;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_fault_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (src_load || src_store) begin
            if (misaligned && !SPLIT_EN) begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_fault_d = 1'b1;
            end else begin
              state_d     = ST_BEAT0;
              cnt_d       = '0;
              bus_req_d   = 1'b1;
              bus_re_d    = src_load;
              bus_we_d    = src_store ? lane_mask[3:0] : 4'b0000;
              bus_addr_d  = word_addr;
              bus_wdata_d = src_store ? lane_data[31:0] : 32'd0;
            end
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
          end
        end
      end

      ST_BEAT0: begin
        if (beat_end) begin
          if (go_beat1) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            state_d     = ST_BEAT1;
            cnt_d       = '0;
            bus_we_d    = src_store ? lane_mask[7:4] : 4'b0000;
            bus_addr_d  = word_addr + ADDR_W'(4);
            bus_wdata_d = src_store ? lane_data[63:32] : 32'd0;
`endif
          end else begin
            state_d     = ST_RESP;
            bus_req_d   = 1'b0;
            bus_re_d    = 1'b0;
            bus_we_d    = 4'b0000;
            bus_addr_d  = '0;
            bus_wdata_d = 32'd0;
            rsp_valid_d = 1'b1;
            rsp_fault_d = beat_fault;
            rsp_rdata_d = (src_load && !beat_fault) ? load_data : 32'd0;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

`ifdef LSU_MISALIGN_SPLIT_EN
      ST_BEAT1: begin
        if (beat_end) begin
          state_d     = ST_RESP;
          bus_req_d   = 1'b0;
          bus_re_d    = 1'b0;
          bus_we_d    = 4'b0000;
          bus_addr_d  = '0;
          bus_wdata_d = 32'd0;
          rsp_valid_d = 1'b1;
          rsp_fault_d = beat_fault;
          rsp_rdata_d = (src_load && !beat_fault) ? load_data : 32'd0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`endif

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, request capture and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= 2'd0;
      sel_q     <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
      bus_req   <= 1'b0;
      bus_re    <= 1'b0;
      bus_we    <= 4'b0000;
      bus_addr  <= '0;
      bus_wdata <= 32'd0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      req_ready <= req_ready_d;
      busy      <= busy_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_fault <= rsp_fault_d;
      bus_req   <= bus_req_d;
      bus_re    <= bus_re_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      if (capture) begin
        op_q    <= mem_op;
        sel_q   <= mem_sel;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
    end
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // First-beat read data held for the split-load merge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= 32'd0;
    end else if (state == ST_BEAT0 && go_beat1) begin
      rdata0_q <= bus_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: table-driven checks of lsu_bus_ctrl (TIMEOUT = 4) plus
// hand-written reset and back-to-back sequences.
module tb_lsu_bus_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  mem_op;
  logic [2:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;
  logic        bus_req;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_bus_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_op(mem_op), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .busy(busy),
    .bus_req(bus_req), .bus_re(bus_re), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          split;
    int          beats;
    logic        re;
    logic [31:0] a0;
    logic [3:0]  we0;
    logic [31:0] d0;
    logic [31:0] r0;
    logic [31:0] a1;
    logic [3:0]  we1;
    logic [31:0] d1;
    logic [31:0] r1;
    int          ack_wait;
    int          err;        // 0 none, 1 err with ack, 2 err alone
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;    // cycles from first post-accept sample to rsp_valid
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  task automatic chk(input string what, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h", what, idx, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int t;
    int seen;
    int wcnt;
    bit in_beat;
    bit done;
    bit gate_bad;
    bit stable_bad;
    logic [31:0] ea;
    logic [3:0]  ewe;
    logic [31:0] ed;
    @(negedge clk);
    req_valid = 1'b1;
    mem_op    = v.op;
    mem_sel   = v.sel;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    chk("req_ready_idle", idx, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_op    = ~v.op;
    mem_sel   = ~v.sel;
    mem_addr  = ~v.addr;
    mem_wdata = ~v.wdata;
    chk("busy_after_accept", idx, 64'({busy, req_ready}), 64'(2'b10));
    t = 0; seen = 0; wcnt = 0; in_beat = 0; done = 0;
    gate_bad = 0; stable_bad = 0;
    ea = 32'd0; ewe = 4'd0; ed = 32'd0;
    while (t < 40 && !done) begin
      if (!bus_req && (bus_re || bus_we != 4'd0)) gate_bad = 1;
      if (rsp_valid) begin
        done    = 1;
        bus_ack = 1'b0;
        bus_err = 1'b0;
        chk("rsp_latency", idx, 64'(t), 64'(v.exp_lat));
        chk("rsp_rdata", idx, 64'(rsp_rdata), 64'(v.exp_rdata));
        chk("rsp_fault", idx, 64'(rsp_fault), 64'(v.exp_fault));
      end else begin
        if (bus_req) begin
          if (!in_beat) begin
            seen++;
            in_beat = 1;
            wcnt = 0;
            ea  = (seen == 1) ? v.a0  : v.a1;
            ewe = (seen == 1) ? v.we0 : v.we1;
            ed  = (seen == 1) ? v.d0  : v.d1;
            chk("bus_addr_wdata", idx, {bus_addr, bus_wdata}, {ea, ed});
            chk("bus_re_we", idx, 64'({bus_re, bus_we}), 64'({v.re, ewe}));
          end else if (bus_addr !== ea || bus_we !== ewe || bus_wdata !== ed || bus_re !== v.re) begin
            stable_bad = 1;
          end
          if (wcnt == v.ack_wait) begin
            bus_ack   = (v.err != 2);
            bus_err   = (v.err != 0);
            bus_rdata = (seen == 1) ? v.r0 : v.r1;
            in_beat   = 0;
          end else begin
            bus_ack   = 1'b0;
            bus_err   = 1'b0;
            bus_rdata = 32'hDEAD_BEEF;
            wcnt++;
          end
        end else begin
          bus_ack = 1'b0;
          bus_err = 1'b0;
          in_beat = 0;
        end
        @(posedge clk);
        #1;
        t++;
      end
    end
    bus_ack = 1'b0;
    bus_err = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_wait vec %0d: no rsp_valid within 40 cycles", idx);
    end
    chk("beat_count", idx, 64'(seen), 64'(v.beats));
    chk("re_we_gated", idx, 64'(gate_bad), 64'd0);
    chk("cmd_stable", idx, 64'(stable_bad), 64'd0);
    @(posedge clk);
    #1;
    chk("back_to_idle", idx, 64'({rsp_valid, req_ready, busy, bus_req}), 64'(4'b0100));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_op = 2'd0; mem_sel = 3'd0;
    mem_addr = 32'd0; mem_wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", -1, 64'(req_ready), 64'd1);
    chk("rst_rsp", -1, {rsp_rdata, 30'd0, rsp_valid, rsp_fault}, 64'd0);
    chk("rst_busy_req", -1, 64'({busy, bus_req, bus_re, bus_we}), 64'd0);
    chk("rst_bus_addr_wdata", -1, {bus_addr, bus_wdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    //            op     sel     addr          wdata         sp bt re a0            we0    d0            r0            a1            we1    d1            r1            aw  er exp_rdata     f  lat
    vecs[0]  = '{2'b01, 3'b010, 32'h0000_0100, 32'h0,        0, 1, 1, 32'h0000_0100, 4'h0, 32'h0,        32'h8765_4321, 32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'h8765_4321, 0, 1};
    vecs[1]  = '{2'b01, 3'b000, 32'h0000_0103, 32'h0,        0, 1, 1, 32'h0000_0100, 4'h0, 32'h0,        32'h8012_3456, 32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'hFFFF_FF80, 0, 1};
    vecs[2]  = '{2'b01, 3'b100, 32'h0000_0103, 32'h0,        0, 1, 1, 32'h0000_0100, 4'h0, 32'h0,        32'h8012_3456, 32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0000_0080, 0, 1};
    vecs[3]  = '{2'b01, 3'b001, 32'h0000_0102, 32'h0,        0, 1, 1, 32'h0000_0100, 4'h0, 32'h0,        32'hFEDC_1234, 32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'hFFFF_FEDC, 0, 1};
    vecs[4]  = '{2'b01, 3'b101, 32'h0000_0102, 32'h0,        0, 1, 1, 32'h0000_0100, 4'h0, 32'h0,        32'hFEDC_1234, 32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0000_FEDC, 0, 1};
    vecs[5]  = '{2'b01, 3'b000, 32'h0000_0101, 32'h0,        0, 1, 1, 32'h0000_0100, 4'h0, 32'h0,        32'h1234_5678, 32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0000_0056, 0, 1};
    vecs[6]  = '{2'b01, 3'b001, 32'h0000_0100, 32'h0,        0, 1, 1, 32'h0000_0100, 4'h0, 32'h0,        32'h1234_8765, 32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'hFFFF_8765, 0, 1};
    vecs[7]  = '{2'b10, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 0, 1, 0, 32'h0000_0100, 4'hC, 32'hBEEF_0000, 32'h1111_1111, 32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0,         0, 1};
    vecs[8]  = '{2'b10, 3'b000, 32'h0000_0101, 32'h1234_56A5, 0, 1, 0, 32'h0000_0100, 4'h2, 32'h0000_A500, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0,         0, 1};
    vecs[9]  = '{2'b10, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 0, 1, 0, 32'h0000_0104, 4'hF, 32'hCAFE_F00D, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0,         0, 1};
    vecs[10] = '{2'b00, 3'b010, 32'h0000_0103, 32'h5555_5555, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0,         0, 0};
    vecs[11] = '{2'b11, 3'b000, 32'h0000_0100, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0,         0, 0};
    vecs[12] = '{2'b01, 3'b011, 32'h0000_0200, 32'h0,        0, 1, 1, 32'h0000_0200, 4'h0, 32'h0,        32'h0102_0304, 32'h0,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0102_0304, 0, 1};
    vecs[13] = '{2'b01, 3'b010, 32'h0000_0100, 32'h0,        0, 1, 1, 32'h0000_0100, 4'h0, 32'h0,        32'h5A5A_0001, 32'h0,        4'h0, 32'h0,        32'h0,        3,  0, 32'h5A5A_0001, 0, 4};
    vecs[14] = '{2'b01, 3'b010, 32'h0000_0100, 32'h0,        0, 1, 1, 32'h0000_0100, 4'h0, 32'h0,        32'h5A5A_0001, 32'h0,        4'h0, 32'h0,        32'h0,        100, 0, 32'h0,         1, 4};
    vecs[15] = '{2'b10, 3'b010, 32'h0000_0108, 32'h1234_5678, 0, 1, 0, 32'h0000_0108, 4'hF, 32'h1234_5678, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        0,  1, 32'h0,         1, 1};
    vecs[16] = '{2'b01, 3'b010, 32'h0000_010C, 32'h0,        0, 1, 1, 32'h0000_010C, 4'h0, 32'h0,        32'hFFFF_FFFF, 32'h0,        4'h0, 32'h0,        32'h0,        0,  2, 32'h0,         1, 1};
    vecs[17] = '{2'b10, 3'b010, 32'h0000_0101, 32'hAABB_CCDD, 1, 2, 0, 32'h0000_0100, 4'hE, 32'hBBCC_DD00, 32'h0,        32'h0000_0104, 4'h1, 32'h0000_00AA, 32'h0,        0,  0, 32'h0,         0, 2};
    vecs[18] = '{2'b01, 3'b010, 32'h0000_0102, 32'h0,        1, 2, 1, 32'h0000_0100, 4'h0, 32'h0,        32'h4433_1111, 32'h0000_0104, 4'h0, 32'h0,        32'h2222_6655, 0,  0, 32'h6655_4433, 0, 2};
    vecs[19] = '{2'b01, 3'b001, 32'h0000_0103, 32'h0,        1, 2, 1, 32'h0000_0100, 4'h0, 32'h0,        32'hAB00_0000, 32'h0000_0104, 4'h0, 32'h0,        32'h0000_00CD, 0,  0, 32'hFFFF_CDAB, 0, 2};
    vecs[20] = '{2'b01, 3'b010, 32'hFFFF_FFFE, 32'h0,        1, 2, 1, 32'hFFFF_FFFC, 4'h0, 32'h0,        32'hBBAA_0000, 32'h0000_0000, 4'h0, 32'h0,        32'h0000_DDCC, 0,  0, 32'hDDCC_BBAA, 0, 2};
    vecs[21] = '{2'b10, 3'b001, 32'h0000_0103, 32'h0000_1234, 1, 2, 0, 32'h0000_0100, 4'h8, 32'h3400_0000, 32'h0,        32'h0000_0104, 4'h1, 32'h0000_0012, 32'h0,        0,  0, 32'h0,         0, 2};
    vecs[22] = '{2'b10, 3'b010, 32'h0000_0101, 32'hAABB_CCDD, 1, 2, 0, 32'h0000_0100, 4'hE, 32'hBBCC_DD00, 32'h0,        32'h0000_0104, 4'h1, 32'h0000_00AA, 32'h0,        2,  0, 32'h0,         0, 6};
    vecs[23] = '{2'b01, 3'b010, 32'h0000_0102, 32'h0,        1, 1, 1, 32'h0000_0100, 4'h0, 32'h0,        32'h4433_1111, 32'h0,        4'h0, 32'h0,        32'h0,        0,  1, 32'h0,         1, 1};

    // Without splitting, a misaligned access faults immediately with no bus beat
    for (int i = 0; i < NV; i++) begin
      if (!SPLIT && vecs[i].split) begin
        vecs[i].beats     = 0;
        vecs[i].exp_rdata = 32'h0;
        vecs[i].exp_fault = 1'b1;
        vecs[i].exp_lat   = 0;
      end
    end

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset asserted in the middle of a BEAT0 wait abandons the beat at once
    @(negedge clk);
    req_valid = 1'b1; mem_op = 2'b01; mem_sel = 3'b010; mem_addr = 32'h0000_0100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_mid_bus_req_before", 100, 64'(bus_req), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_bus", 100, 64'({bus_req, bus_re, bus_we}), 64'd0);
    chk("rst_mid_ready_busy", 100, 64'({req_ready, busy, rsp_valid}), 64'(3'b100));
    chk("rst_mid_bus_addr", 100, 64'(bus_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(101, vecs[0]);

    // Request held high: the next accept happens in the cycle after RESP
    @(negedge clk);
    req_valid = 1'b1; mem_op = 2'b00; mem_sel = 3'b010; mem_addr = 32'h0;
    @(posedge clk);
    #1;
    chk("b2b_first_rsp", 102, 64'({rsp_valid, req_ready}), 64'(2'b10));
    @(posedge clk);
    #1;
    chk("b2b_gap_idle", 102, 64'({rsp_valid, req_ready}), 64'(2'b01));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("b2b_second_rsp", 102, 64'({rsp_valid, req_ready, rsp_fault}), 64'(3'b100));
    @(posedge clk);
    #1;
    chk("b2b_done_idle", 102, 64'({rsp_valid, req_ready, busy}), 64'(3'b010));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width (>=3); data path fixed at 32 bits.
REQ-002 Parameter TIMEOUT, default 16, max bus-wait cycles per beat before fault (1..255).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid in 1 / req_ready out 1  request handshake; transfer when both high on a clock edge.
REQ-006 mem_op  in  2  00 none, 01 load, 10 store, 11 none.
REQ-007 mem_sel  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W.
REQ-008 mem_addr in ADDR_W / mem_wdata in 32  byte address, store data (right-aligned).
REQ-009 rsp_valid out 1 / rsp_rdata out 32 / rsp_fault out 1  one-cycle response.
REQ-010 busy  out  1  high whenever state != IDLE.
REQ-011 bus_req out 1 / bus_re out 1 / bus_we out 4 / bus_addr out ADDR_W / bus_wdata out 32  bus command.
REQ-012 bus_ack in 1 / bus_rdata in 32 / bus_err in 1  bus completion; sampled only while bus_req high.

Function
REQ-013 States: IDLE, BEAT0, BEAT1, RESP; req_ready high only in IDLE.
REQ-014 On accept, capture op, sel, addr, wdata; later input changes are ignored.
REQ-015 op none: IDLE->RESP, no bus activity, rsp_rdata 0, rsp_fault 0.
REQ-016 Load/store: IDLE->BEAT0; bus_req high in BEAT0/BEAT1, command stable until bus_ack or bus_err.
REQ-017 bus_addr = word-aligned address (low 2 bits 0); bus_re = load; bus_we = store byte mask shifted by addr[1:0] (B 0001, H 0011, W 1111); bus_wdata = data shifted left by 8*addr[1:0].
REQ-018 Aligned access, bus_ack in first BEAT0 cycle: accept at N, bus_req at N+1, rsp_valid at N+2.
REQ-019 Load result: selected bytes right-aligned; B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-020 Misaligned = H at offset 3, or W at offset 1..3; handling per Configuration.
REQ-021 Split beat1 addresses next word; wraps modulo 2^ADDR_W; mask/data carry the remaining upper bytes at lane 0 upward.
REQ-022 Split load merges beat0 upper lanes (low bytes) with beat1 lower lanes before extension.
REQ-023 Wait counter clears on entering each beat, increments per cycle without ack/err; reaching TIMEOUT -> RESP with fault.
REQ-024 bus_err -> RESP with fault, beat1 skipped; bus_err with bus_ack same cycle = err.
REQ-025 Fault response: rsp_rdata 0, rsp_fault 1; no store beat follows a faulted beat.
REQ-026 RESP lasts exactly one cycle then IDLE; earliest next accept is the cycle after RESP.

Reset
REQ-027 rst asserted: state IDLE, counter 0, captured regs 0 immediately, any bus beat abandoned.
REQ-028 Reset outputs: req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_fault 0, busy 0, bus_req 0, bus_re 0, bus_we 0, bus_addr 0, bus_wdata 0.
REQ-029 bus_re/bus_we are 0 whenever bus_req is 0.

Configuration
REQ-030 Macro LSU_MISALIGN_SPLIT_EN defined: misaligned access runs BEAT0 then BEAT1 (two bus transactions).
REQ-031 Macro undefined: misaligned access goes IDLE->RESP with fault, no bus activity; BEAT1 logic absent.

Verification
REQ-032 LW addr 0x100, bus_rdata 0x8765_4321 ack immediate -> bus_addr 0x100, bus_re 1, rsp_rdata 0x8765_4321, rsp_valid at N+2.
REQ-033 LB addr 0x103, bus_rdata 0x80xx_xxxx -> rsp_rdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-034 SH addr 0x102 data 0x0000_BEEF -> bus_we 1100, bus_wdata 0xBEEF_0000.
REQ-035 SW addr 0x101 data 0xAABB_CCDD, macro on -> beat0 0x100 we 1110 data 0xBBCC_DD00, beat1 0x104 we 0001 data 0x0000_00AA; macro off -> fault, no bus_req.
REQ-036 No ack for TIMEOUT=4 cycles -> rsp_fault 1; rst pulsed mid-BEAT0 -> bus_req 0 immediately, req_ready 1.
